// File: rtl/sc_result_framer.sv
// sc_result_framer: frames each adder result as a UART-style serial word with a one-deep pending buffer
module sc_result_framer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_start,
  output logic [7:0]        drop_cnt
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_IDX = 4'(DATA_W - 1);
  state_t state;
  logic [15:0] bit_cnt;
  logic [3:0] idx;
  logic [DATA_W-1:0] shreg, pend, pend_n, word;
  logic pend_full, par, last, go, pend_full_n, drop_inc;
  // A new frame may start from IDLE or in the final STOP cycle; pending always wins the shifter
  always_comb begin
    last = bit_cnt == LAST_CNT;
    go = (state == IDLE || (state == STOP && last)) && (pend_full || in_valid);
    word = pend_full ? pend : in_data;
    pend_full_n = go ? pend_full && in_valid : pend_full || in_valid;
    pend_n = in_valid && (!go || pend_full) ? in_data : pend;
    drop_inc = !go && in_valid && pend_full && drop_cnt != 8'hff;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      idx <= '0;
      shreg <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      par <= 1'b0;
      in_ready <= 1'b1;
      ser_out <= 1'b1;
      busy <= 1'b0;
      frame_start <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pend_full <= pend_full_n;
      pend <= pend_n;
      in_ready <= !pend_full_n;
      frame_start <= go;
      if (drop_inc) drop_cnt <= drop_cnt + 8'd1;
      bit_cnt <= (state == IDLE || last || go) ? '0 : bit_cnt + 16'd1;
      if (go) begin
        state <= START;
        shreg <= word;
        par <= ^word;
        ser_out <= 1'b0;
        busy <= 1'b1;
      end else if (last) begin
        case (state)
          START: begin
            state <= DATA;
            idx <= '0;
            ser_out <= shreg[0];
            shreg <= shreg >> 1;
          end
          DATA: begin
            if (idx == LAST_IDX) begin
              state <= PARITY;
              ser_out <= par;
            end else begin
              idx <= idx + 4'd1;
              ser_out <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
          PARITY: begin
            state <= STOP;
            ser_out <= 1'b1;
          end
          STOP: begin
            state <= IDLE;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
